// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl
// OAM DMA controller and arbiter for the single shared memory port.
// A CPU write to DMA_REG_ADDR loads the source page and copies DMA_LEN bytes
// from {src_page,8'h00} to OAM_BASE. During the copy the DMA owns the bus and
// CPU traffic is blocked. When idle, CPU traffic passes straight through.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_cpu_rd_addr        CPU read address
//   i_cpu_wr_en/addr/data  CPU write request
//   o_cpu_rd_data        read data returned to the CPU
//   o_mem_rd_addr        memory read address (memory read is asynchronous)
//   i_mem_rd_data        memory read data, valid in the same cycle
//   o_mem_wr_en/addr/data  memory write request, sampled at the rising edge
//   o_dma_active         high while the DMA owns the bus
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int unsigned DMA_LEN      = 160
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_rd_addr,
  input  logic        i_cpu_wr_en,
  input  logic [15:0] i_cpu_wr_addr,
  input  logic [7:0]  i_cpu_wr_data,
  output logic [7:0]  o_cpu_rd_data,
  output logic [15:0] o_mem_rd_addr,
  input  logic [7:0]  i_mem_rd_data,
  output logic        o_mem_wr_en,
  output logic [15:0] o_mem_wr_addr,
  output logic [7:0]  o_mem_wr_data,
  output logic        o_dma_active
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    READ,
    WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] src_page;
  logic [7:0] idx;
  logic [7:0] rd_buf;
  logic       dma_reg_wr;

  // Writes to the DMA register are consumed here in every state.
  assign dma_reg_wr = i_cpu_wr_en && (i_cpu_wr_addr == DMA_REG_ADDR);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      src_page <= 8'hFF;
      idx      <= 8'h00;
      rd_buf   <= 8'h00;
    end else begin
      state <= state_next;
      if (state == READ) begin
        rd_buf <= i_mem_rd_data;
      end
      // A (re)start overrides the index advance of a concurrent WRITE cycle.
      if (dma_reg_wr) begin
        src_page <= i_cpu_wr_data;
        idx      <= 8'h00;
      end else if (state == WRITE && idx != LAST_IDX) begin
        idx <= idx + 8'd1;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = IDLE;
      START:   state_next = READ;
      READ:    state_next = WRITE;
      WRITE:   state_next = (idx == LAST_IDX) ? IDLE : READ;
      default: state_next = IDLE;
    endcase
    // Restart wins over both WRITE exits.
    if (dma_reg_wr) begin
      state_next = START;
    end
  end

  always_comb begin
    o_mem_rd_addr = i_cpu_rd_addr;
    o_mem_wr_addr = i_cpu_wr_addr;
    o_mem_wr_data = i_cpu_wr_data;
    o_mem_wr_en   = 1'b0;
    o_cpu_rd_data = 8'hFF;
    unique case (state)
      IDLE: begin
        // Reset forces the strobe low even though IDLE passes traffic through.
        o_mem_wr_en   = i_cpu_wr_en && !dma_reg_wr && !i_rst;
        o_cpu_rd_data = i_mem_rd_data;
      end
      START: begin
      end
      READ: begin
        o_mem_rd_addr = {src_page, idx};
      end
      WRITE: begin
        o_mem_wr_en   = 1'b1;
        o_mem_wr_addr = OAM_BASE + {8'h00, idx};
        o_mem_wr_data = rd_buf;
      end
      default: begin
      end
    endcase
    // The source register is readable whether or not the DMA owns the bus.
    if (i_cpu_rd_addr == DMA_REG_ADDR) begin
      o_cpu_rd_data = src_page;
    end
  end

  assign o_dma_active = (state != IDLE);

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

OAM DMA controller and memory-bus arbiter between the CPU and the single shared memory port. It owns the DMA source register at FF46. A CPU write to that register starts a 160-byte copy from page `{src,8'h00}` into OAM at FE00–FE9F. While the copy runs, the block holds the memory bus and blocks the CPU's memory accesses. Sits between `cpu` and the memory/address decoder. When idle it passes CPU traffic through transparently.

## Interface
Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU-visible DMA source register address
- OAM_BASE, 16'hFE00, destination base address
- DMA_LEN, 160, bytes per transfer (≤256)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_cpu_rd_addr  in  16  CPU read address
- i_cpu_wr_en  in  1  CPU write strobe
- i_cpu_wr_addr  in  16  CPU write address
- i_cpu_wr_data  in  8  CPU write data
- o_cpu_rd_data  out  8  read data returned to CPU
- o_mem_rd_addr  out  16  memory read address; memory read is asynchronous, data valid in the same cycle
- i_mem_rd_data  in  8  memory read data
- o_mem_wr_en  out  1  memory write strobe, sampled at the rising edge
- o_mem_wr_addr  out  16  memory write address
- o_mem_wr_data  out  8  memory write data
- o_dma_active  out  1  high while the DMA owns the bus

## Operation
Registers:
- src_page[7:0]: reset 8'hFF.
- idx[7:0]: reset 0.
- rd_buf[7:0]: reset 0.
- state: reset IDLE.

States:
- IDLE → START on a CPU write to DMA_REG_ADDR.
- START (1 cycle) → READ.
- READ: drive `o_mem_rd_addr={src_page,idx}`; capture `i_mem_rd_data` into rd_buf at the edge → WRITE.
- WRITE: drive `o_mem_wr_en=1`, `o_mem_wr_addr=OAM_BASE+idx`, `o_mem_wr_data=rd_buf`. Then:
  - if idx==DMA_LEN-1 → IDLE;
  - else idx+1 → READ.
- idx is 8-bit. The destination address is a 16-bit add with no wrap. The source never crosses the page.
- src_page is used verbatim; there is no echo remapping.

CPU writes to DMA_REG_ADDR (any state):
- load src_page with i_cpu_wr_data, clear idx, go to START;
- are never forwarded to memory (o_mem_wr_en=0 for them).

A write to DMA_REG_ADDR while non-IDLE restarts the transfer from idx 0 with the new page. A write issued by the current WRITE cycle in that same cycle still completes. Restart has priority over the WRITE→IDLE and WRITE→READ transitions.

IDLE (pass-through, combinational):
- o_mem_rd_addr=i_cpu_rd_addr, o_mem_wr_addr=i_cpu_wr_addr, o_mem_wr_data=i_cpu_wr_data.
- o_mem_wr_en=i_cpu_wr_en except for DMA_REG_ADDR.
- o_cpu_rd_data=i_mem_rd_data.

START/READ/WRITE (bus owned by the DMA):
- CPU writes other than to DMA_REG_ADDR are dropped.
- CPU reads return 8'hFF.
- In START, memory outputs are driven with o_mem_wr_en=0 and o_mem_rd_addr=i_cpu_rd_addr (don't-care).

A CPU read of DMA_REG_ADDR returns src_page in every state.

o_dma_active is 1 in START/READ/WRITE and 0 in IDLE, decoded from the registered state.

## Timing
Reset:
- While i_rst is high: state=IDLE, o_dma_active=0, o_mem_wr_en=0.
- Other memory outputs follow the pass-through equations.
- Asserting reset mid-transfer aborts immediately. No further OAM writes occur and idx is discarded.

Transfer latency:
- CPU write to FF46 in cycle C0.
- START in C1 (o_dma_active=1 from C1).
- READ byte k in C2+2k, WRITE byte k in C3+2k.
- Last OAM write in C1+2·DMA_LEN (C321 for 160 bytes); IDLE and o_dma_active=0 in C322.
- Total 2·DMA_LEN+1 active cycles.

Throughput: one OAM byte every 2 cycles. No back-pressure.

Pass-through in IDLE is zero-latency (combinational). The block adds no register stage to CPU accesses.

## Test plan
- Reset, then a CPU write of 8'hC1 to FF46 in C0 → o_dma_active rises at C1. OAM FE00..FE9F receives bytes from C100..C19F, one write every 2 cycles, last at C321. o_dma_active falls at C322. FF46 is never written to memory.
- During a transfer, CPU reads 16'hC000 → o_cpu_rd_data=8'hFF. CPU writes 8'h55 to 16'hD000 → no memory write. CPU read of FF46 → 8'hC1.
- At idx 50, CPU writes 8'hD0 to FF46 → the byte-50 WRITE in progress completes. START follows, then a copy of D000..D09F to FE00..FE9F from idx 0. The transfer ends 321 cycles after the restart write.
- Restart write coincident with the final WRITE (idx 159) → FE9F is written. The block goes to START, not IDLE, and o_dma_active stays high.
- Assert i_rst at idx 80 → o_dma_active=0 and o_mem_wr_en=0 immediately. After release, src_page reads 8'hFF and pass-through works: a CPU write of 8'hAA to C123 writes memory in the same cycle.
- IDLE pass-through: CPU read of 16'h0100 with memory data 8'h31 → o_cpu_rd_data=8'h31 in the same cycle, and o_mem_rd_addr=16'h0100.
